seven_segment_scan_controller: RTL and testbench

//  Parametrised multiplexed 7-segment driver, successor of the fixed 8-digit controller.

---
 rtl/seven_segment_scan_controller.sv | 194 +++++++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed 7-segment scan driver showing data_in in HEX or DECIMAL (sequential double-dabble).
// Build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS      = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int REFRESH_DIV     = 4096,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  system_clock,
    input  logic                  cpu_rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  mode_btn,
    output logic [6:0]            cathodes_out,
    output logic [NUM_DIGITS-1:0] anode_out,
    output logic                  mode_out,
    output logic                  conv_busy
);
    // ceil(DATA_WIDTH/3) BCD digits always hold the value, since 8^k < 10^k
    localparam int BCD_DIGITS = (DATA_WIDTH + 2) / 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int HEX_W      = 4 * NUM_DIGITS;
    localparam int HEX_PAD_W  = (DATA_WIDTH > HEX_W) ? DATA_WIDTH : HEX_W;
    localparam int BCD_PAD_W  = (BCD_W > HEX_W) ? BCD_W : HEX_W;
    localparam int CNT_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BIT_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Debounce: one toggle when the stable-high count first reaches DEBOUNCE_CYCLES, then saturate
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            db_cnt   <= '0;
            mode_out <= 1'b0;
        end else if (!mode_btn) begin
            db_cnt <= '0;
        end else if (db_cnt != DB_LAST) begin
            db_cnt <= db_cnt + 1'b1;
            if (db_cnt == DB_LAST - 1'b1)
                mode_out <= ~mode_out;
        end
    end

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

    conv_state_t                  state;
    logic [DATA_WIDTH-1:0]        last_data;
    logic                         last_mode;
    logic [DATA_WIDTH-1:0]        bin_sr;
    logic [BCD_W-1:0]             bcd;
    logic [BCD_W-1:0]             bcd_adj;
    logic [BIT_W-1:0]             bit_cnt;
    logic [NUM_DIGITS-1:0][3:0]   disp;
    logic                         disp_ovf;
    logic [NUM_DIGITS-1:0][3:0]   load_digits;
    logic                         load_ovf;
    logic [HEX_PAD_W-1:0]         hex_pad;
    logic [BCD_PAD_W-1:0]         bcd_pad;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    assign hex_pad = HEX_PAD_W'(last_data);
    assign bcd_pad = BCD_PAD_W'(bcd);

    // Anything left above the visible digits means the value does not fit
    always_comb begin
        if (last_mode) begin
            load_digits = bcd_pad[HEX_W-1:0];
            load_ovf    = |(bcd_pad >> HEX_W);
        end else begin
            load_digits = hex_pad[HEX_W-1:0];
            load_ovf    = |(hex_pad >> HEX_W);
        end
    end

    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            state     <= IDLE;
            last_data <= '0;
            last_mode <= 1'b0;
            bin_sr    <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            disp      <= '0;
            disp_ovf  <= 1'b0;
            conv_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_in != last_data || mode_out != last_mode) begin
                        last_data <= data_in;
                        last_mode <= mode_out;
                        bin_sr    <= data_in;
                        bcd       <= '0;
                        bit_cnt   <= '0;
                        conv_busy <= 1'b1;
                        state     <= mode_out ? SHIFT : LOAD;
                    end
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    bit_cnt       <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST)
                        state <= LOAD;
                end
                LOAD: begin
                    disp      <= load_digits;
                    disp_ovf  <= load_ovf;
                    conv_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_DIGITS-1:0] blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic nz_seen;

    always_comb begin
        blank   = '0;
        nz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (disp[i] != 4'h0)
                nz_seen = 1'b1;
            blank[i] = !nz_seen;
        end
    end
`else
    assign blank = '0;
`endif

    logic [CNT_W-1:0] ref_cnt, ref_cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;

    always_comb begin
        ref_cnt_nxt = (ref_cnt == CNT_LAST) ? '0 : ref_cnt + 1'b1;
        idx_nxt     = idx;
        if (ref_cnt == CNT_LAST)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // Outputs are registered from next-state counters so anode/cathode track ref_cnt/idx exactly
    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            ref_cnt      <= '0;
            idx          <= '0;
            anode_out    <= '1;
            cathodes_out <= SEG_BLANK;
        end else begin
            ref_cnt      <= ref_cnt_nxt;
            idx          <= idx_nxt;
            anode_out    <= (ref_cnt_nxt == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
            cathodes_out <= disp_ovf       ? SEG_DASH  :
                            blank[idx_nxt] ? SEG_BLANK : seg7(disp[idx_nxt]);
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: 8-digit and 4-digit instances on shared stimulus,
// vector table + scoreboard of expected frames, plus debounce/reset/mid-conversion sequences.
module tb_seven_segment_scan_controller;
    localparam int RD = 4;
    localparam int DB = 4;
    localparam int DW = 16;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_btn = 1'b0;
    logic [15:0] data_in = '0;
    logic [6:0]  cath8, cath4;
    logic [7:0]  an8;
    logic [3:0]  an4;
    logic        mode8, mode4, busy8, busy4;

    seven_segment_scan_controller #(.NUM_DIGITS(8), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DB)) dut8 (
        .system_clock(clk), .cpu_rst(rst), .data_in(data_in), .mode_btn(mode_btn),
        .cathodes_out(cath8), .anode_out(an8), .mode_out(mode8), .conv_busy(busy8));

    seven_segment_scan_controller #(.NUM_DIGITS(4), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DB)) dut4 (
        .system_clock(clk), .cpu_rst(rst), .data_in(data_in), .mode_btn(mode_btn),
        .cathodes_out(cath4), .anode_out(an4), .mode_out(mode4), .conv_busy(busy4));

    always #5 clk = ~clk;

    typedef struct { logic dec; logic [15:0] data; int nd; } vec_t;
    typedef struct { logic [15:0][6:0] cath; int busy; int nd; } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int unsigned d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001;  14: return 7'b0000110;  15: return 7'b0001110;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference frame from repeated div/mod in the chosen base
    function automatic logic [15:0][6:0] model(input logic dec, input logic [15:0] data, input int nd);
        int unsigned v, base;
        int unsigned dig[16];
        int msd;
        logic [15:0][6:0] r;
        r = '1;
        v = data;
        base = dec ? 10 : 16;
        msd = 0;
        for (int i = 0; i < nd; i++) begin
            dig[i] = v % base;
            v = v / base;
            if (dig[i] != 0) msd = i;
        end
        for (int i = 0; i < nd; i++)
            r[i] = (v != 0) ? 7'b0111111 : (BLANK_EN && i > msd) ? 7'h7F : enc(dig[i]);
        return r;
    endfunction

    task automatic press(input logic [31:0] seq, input int len, output int tg);
        logic prev;
        tg = 0;
        prev = mode8;
        for (int k = 0; k < len + 3; k++) begin
            mode_btn = (k < len) ? seq[k] : 1'b0;
            @(negedge clk);
            if (mode8 !== prev) tg++;
            prev = mode8;
        end
    endtask

    task automatic settle();
        for (int k = 0; k < 100 && busy8; k++) @(negedge clk);
        check("settle_busy", busy8, 1'b0);
    endtask

    task automatic wait_conv(output int n, input int chg_at, input logic [15:0] chg_data);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == chg_at) data_in = chg_data;
            if (busy8) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic scan(input int nd, output logic [15:0][6:0] got, output bit ok);
        bit hit;
        ok = 1'b1;
        got = '1;
        for (int i = 0; i < nd; i++) begin
            hit = 1'b0;
            for (int k = 0; k < 200 && !hit; k++) begin
                @(negedge clk);
                if (nd == 8 && an8 == ~(8'd1 << i)) begin got[i] = cath8; hit = 1'b1; end
                if (nd == 4 && an4 == ~(4'd1 << i)) begin got[i] = cath4; hit = 1'b1; end
            end
            if (!hit) ok = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input exp_t e);
        logic [15:0][6:0] got;
        bit ok;
        scan(e.nd, got, ok);
        check({tag, "_scan_found"}, ok, 1'b1);
        for (int i = 0; i < e.nd; i++)
            check($sformatf("%s_digit%0d", tag, i), got[i], e.cath[i]);
    endtask

    task automatic apply(input int vi, input vec_t v);
        exp_t e;
        int n, tg;
        if (v.dec != mode8) begin
            press(32'b1111111111101, 13, tg);
            check($sformatf("v%0d_press_toggles", vi), tg, 1);
            check($sformatf("v%0d_mode_out", vi), mode8, v.dec);
            settle();
        end
        e.cath = model(v.dec, v.data, v.nd);
        e.busy = v.dec ? DW + 1 : 1;
        e.nd   = v.nd;
        sb.push_back(e);
        data_in = v.data;
        wait_conv(n, -1, 16'h0);
        e = sb.pop_front();
        check($sformatf("v%0d_busy_cycles", vi), n, e.busy);
        check_frame($sformatf("v%0d", vi), e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tg, ff_cnt, bad, seen;
        exp_t e;

        vecs[0]  = '{1'b0, 16'hA2DF, 8};
        vecs[1]  = '{1'b0, 16'h007D, 8};
        vecs[2]  = '{1'b0, 16'h0000, 8};
        vecs[3]  = '{1'b1, 16'd12345, 8};
        vecs[4]  = '{1'b1, 16'd65535, 8};
        vecs[5]  = '{1'b1, 16'd0, 8};
        vecs[6]  = '{1'b1, 16'd9999, 4};
        vecs[7]  = '{1'b1, 16'd10000, 4};
        vecs[8]  = '{1'b1, 16'hFFFF, 4};
        vecs[9]  = '{1'b0, 16'h1234, 8};
        vecs[10] = '{1'b0, 16'hFFFF, 4};

        repeat (3) @(negedge clk);
        check("rst_anode", an8, 8'hFF);
        check("rst_cath", cath8, 7'h7F);
        check("rst_mode", mode8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        rst = 1'b0;

        // Anti-ghost slot: exactly one all-off sample per REFRESH_DIV cycles, otherwise one-cold
        ff_cnt = 0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (an8 == 8'hFF) ff_cnt++;
            else if ($countones(~an8) != 1) bad++;
        end
        check("guard_ff_count", ff_cnt, 4);
        check("guard_onecold", bad, 0);

        for (int vi = 0; vi < 11; vi++) apply(vi, vecs[vi]);

        // One cycle short of the debounce threshold
        press(32'b111, 3, tg);
        check("short_press_toggles", tg, 0);
        check("short_press_mode", mode8, 1'b0);

        press(32'b1111111111101, 13, tg);
        check("dec_press_toggles", tg, 1);
        settle();

        // Change during SHIFT is deferred: 5555 is shown, then 125
        e.cath = model(1'b1, 16'd5555, 8); e.busy = DW + 1; e.nd = 8;
        sb.push_back(e);
        data_in = 16'd5555;
        e.cath = model(1'b1, 16'd125, 8); e.busy = DW + 1; e.nd = 8;
        sb.push_back(e);
        wait_conv(n, 4, 16'd125);
        e = sb.pop_front();
        check("midshift_busy_cycles", n, e.busy);
        seen = 0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++)
                if (an8 == ~(8'd1 << j)) begin
                    seen++;
                    if (cath8 !== e.cath[j]) bad++;
                end
        end
        check("midshift_old_frame_samples", seen >= 6, 1'b1);
        check("midshift_old_frame_bad", bad, 0);
        check("midshift_rebusy", busy8, 1'b1);
        settle();
        e = sb.pop_front();
        check_frame("midshift_new", e);

        // Reset in the middle of a DECIMAL conversion
        data_in = 16'h4321;
        repeat (5) @(negedge clk);
        check("midconv_busy", busy8, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midconv_rst_anode", an8, 8'hFF);
        check("midconv_rst_cath", cath8, 7'h7F);
        check("midconv_rst_busy", busy8, 1'b0);
        check("midconv_rst_mode", mode8, 1'b0);
        e.cath = model(1'b0, 16'h4321, 8); e.busy = 1; e.nd = 8;
        sb.push_back(e);
        rst = 1'b0;
        wait_conv(n, -1, 16'h0);
        e = sb.pop_front();
        check("post_rst_busy_cycles", n, e.busy);
        check_frame("post_rst", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
